// File: rtl/sao_sched_pkg.sv
// Shared limits, width helpers and one-hot decode for the SAO slot scheduler.
// Imported by the arbiter and the scheduler top.
package sao_sched_pkg;

    localparam int MULT_MIN = 2;
    localparam int MULT_MAX = 16;
    localparam int NREQ_MIN = 2;
    localparam int NREQ_MAX = 8;

    localparam int MULT_DEF = 3;
    localparam int NREQ_DEF = 4;

    localparam int PW_MAX = 4;
    localparam int IW_MAX = 3;

    function automatic int pw_of(input int m);
        return ($clog2(m) > 1) ? $clog2(m) : 1;
    endfunction

    function automatic int iw_of(input int n);
        return ($clog2(n) > 1) ? $clog2(n) : 1;
    endfunction

    localparam int PW = pw_of(MULT_DEF);
    localparam int IW = iw_of(NREQ_DEF);

    // Zero input decodes to index 0.
    function automatic logic [IW_MAX-1:0] onehot2idx(
        input logic [NREQ_MAX-1:0] oh
    );
        logic [IW_MAX-1:0] idx;
        idx = '0;
        for (int i = 0; i < NREQ_MAX; i++) begin
            if (oh[i]) begin
                idx = idx | IW_MAX'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/sao_rr_arb.sv
// Combinational round-robin search: first set request at or after ptr,
// wrapping modulo NREQ.
module sao_rr_arb
    import sao_sched_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    localparam int IDW = iw_of(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic            vld_o,
    output logic [IDW-1:0]  idx_o
);

    int             k;
    logic [IDW-1:0] kk;

    always_comb begin
        gnt_o = '0;
        vld_o = 1'b0;
        idx_o = '0;
        k     = 0;
        kk    = '0;
        for (int i = 0; i < NREQ; i++) begin
            k = int'(ptr_i) + i;
            if (k >= NREQ) begin
                k = k - NREQ;
            end
            kk = IDW'(k);
            if (!vld_o && req_i[kk]) begin
                vld_o     = 1'b1;
                gnt_o[kk] = 1'b1;
                idx_o     = kk;
            end
        end
    end

endmodule

// File: rtl/sao_slot_sched.sv
// SAO datapath slot scheduler: phase counter, slow-domain strobe and
// reserved slot, plus registered round-robin grant of the shared slot.
module sao_slot_sched
    import sao_sched_pkg::*;
#(
    parameter int MULT = MULT_DEF,
    parameter int NREQ = NREQ_DEF,
    localparam int PHW = pw_of(MULT),
    localparam int IDW = iw_of(NREQ)
) (
    input  logic            clk,
    input  logic            arst,
    input  logic            en,
    input  logic            sclr,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id,
    output logic [PHW-1:0]  phase,
    output logic            slow_ce,
    output logic            rsv
);

    localparam logic [PHW-1:0] PH_LAST = PHW'(MULT - 1);
    localparam logic [IDW-1:0] ID_LAST = IDW'(NREQ - 1);

    logic [PHW-1:0]  phase_q, phase_d, phase_inc;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [IDW-1:0]  gnt_id_q, gnt_id_d;
    logic            slow_ce_q, slow_ce_d;
    logic            rsv_q, rsv_d;

    logic [NREQ-1:0] arb_req;
    logic [NREQ-1:0] arb_gnt;
    logic            arb_vld;
    logic [IDW-1:0]  arb_idx;

    // Current holder is masked so nobody gets two slots back to back.
    assign arb_req = req & ~gnt_q;

    sao_rr_arb #(
        .NREQ (NREQ)
    ) u_arb (
        .req_i (arb_req),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .vld_o (arb_vld),
        .idx_o (arb_idx)
    );

    assign phase_inc = (phase_q == PH_LAST) ? '0 : phase_q + PHW'(1);

    always_comb begin
        phase_d   = phase_q;
        ptr_d     = ptr_q;
        gnt_d     = '0;
        slow_ce_d = 1'b0;
        if (sclr) begin
            phase_d = '0;
            ptr_d   = '0;
        end else if (en) begin
            phase_d   = phase_inc;
            slow_ce_d = (phase_inc == PH_LAST);
            // Phase 0 belongs to the slow-domain writeback.
            if ((phase_inc != '0) && arb_vld) begin
                gnt_d = arb_gnt;
                ptr_d = (arb_idx == ID_LAST) ? '0 : arb_idx + IDW'(1);
            end
        end
        gnt_id_d = IDW'(onehot2idx(NREQ_MAX'(gnt_d)));
        rsv_d    = (phase_d == '0);
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            phase_q   <= '0;
            ptr_q     <= '0;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            slow_ce_q <= 1'b0;
            rsv_q     <= 1'b1;
        end else begin
            phase_q   <= phase_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            slow_ce_q <= slow_ce_d;
            rsv_q     <= rsv_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_id  = gnt_id_q;
    assign phase   = phase_q;
    assign slow_ce = slow_ce_q;
    assign rsv     = rsv_q;

endmodule
